// File: rtl/io_responder.sv
// Core-side I/O responder: per-channel input holding registers plus an output FIFO toward a consumer.
// Define IO_RESPONDER_ERRFLAG_EN to build the sticky overflow/underrun flags; otherwise they are tied low.
module io_responder #(
    parameter int NUBITS = 32,
    parameter int NUIOIN = 8,
    parameter int NUIOOU = 8,
    parameter int FDEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_in,
    input  logic [$clog2(NUIOIN)-1:0]    addr_in,
    output logic [NUBITS-1:0]            io_in,
    input  logic                         out_en,
    input  logic [$clog2(NUIOOU)-1:0]    addr_out,
    input  logic [NUBITS-1:0]            data_out,
    input  logic [NUIOIN*NUBITS-1:0]     ext_in_data,
    input  logic [NUIOIN-1:0]            ext_in_valid,
    output logic [NUIOIN-1:0]            ext_in_ready,
    output logic [NUBITS-1:0]            ext_out_data,
    output logic [$clog2(NUIOOU)-1:0]    ext_out_addr,
    output logic                         ext_out_valid,
    input  logic                         ext_out_ready,
    output logic                         err_ovf,
    output logic                         err_unf
);
    localparam int IW = $clog2(NUIOIN);
    localparam int OW = $clog2(NUIOOU);
    localparam int PW = $clog2(FDEPTH);
    localparam int CW = PW + 1;
    localparam int EW = OW + NUBITS;

    logic [NUBITS-1:0] hold [NUIOIN];
    logic [NUIOIN-1:0] full;

    generate
        for (genvar gi = 0; gi < NUIOIN; gi++) begin : g_chan
            logic              sel;
            logic              load;
            logic              full_reg;
            logic [NUBITS-1:0] hold_reg;

            assign sel              = req_in && (addr_in == IW'(gi));
            // A read on this channel frees the slot in the same cycle, so a producer can refill it back-to-back.
            assign ext_in_ready[gi] = !full_reg || sel;
            assign load             = ext_in_valid[gi] && ext_in_ready[gi];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    full_reg <= 1'b0;
                    hold_reg <= '0;
                end else if (load) begin
                    full_reg <= 1'b1;
                    hold_reg <= ext_in_data[gi*NUBITS +: NUBITS];
                end else if (sel) begin
                    full_reg <= 1'b0;
                end
            end

            assign full[gi] = full_reg;
            assign hold[gi] = hold_reg;
        end
    endgenerate

    assign io_in = hold[addr_in];

    logic [EW-1:0] mem [FDEPTH];
    logic [PW-1:0] wr_ptr_reg;
    logic [PW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic          fifo_full;
    logic          push;
    logic          pop;

    assign fifo_full     = (count_reg == CW'(FDEPTH));
    assign ext_out_valid = (count_reg != '0);
    assign pop           = ext_out_valid && ext_out_ready;
    assign push          = out_en && (!fifo_full || pop);
    assign {ext_out_addr, ext_out_data} = mem[rd_ptr_reg];

    // Storage carries no reset; count_reg alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {addr_out, data_out};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

`ifdef IO_RESPONDER_ERRFLAG_EN
    logic err_ovf_reg;
    logic err_unf_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_ovf_reg <= 1'b0;
            err_unf_reg <= 1'b0;
        end else begin
            if (out_en && fifo_full && !pop) begin
                err_ovf_reg <= 1'b1;
            end
            if (req_in && !full[addr_in]) begin
                err_unf_reg <= 1'b1;
            end
        end
    end

    assign err_ovf = err_ovf_reg;
    assign err_unf = err_unf_reg;
`else
    assign err_ovf = 1'b0;
    assign err_unf = 1'b0;
`endif

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder at default parameters; expected flag values follow IO_RESPONDER_ERRFLAG_EN.
module tb_io_responder;
`ifdef IO_RESPONDER_ERRFLAG_EN
    localparam logic EF = 1'b1;
`else
    localparam logic EF = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         req_in;
    logic [2:0]   addr_in;
    logic [31:0]  io_in;
    logic         out_en;
    logic [2:0]   addr_out;
    logic [31:0]  data_out;
    logic [255:0] ext_in_data;
    logic [7:0]   ext_in_valid;
    logic [7:0]   ext_in_ready;
    logic [31:0]  ext_out_data;
    logic [2:0]   ext_out_addr;
    logic         ext_out_valid;
    logic         ext_out_ready;
    logic         err_ovf;
    logic         err_unf;

    int vectors = 0;
    int miscompares = 0;

    io_responder #(.NUBITS(32), .NUIOIN(8), .NUIOOU(8), .FDEPTH(4)) dut (
        .clk(clk), .rst(rst), .req_in(req_in), .addr_in(addr_in), .io_in(io_in),
        .out_en(out_en), .addr_out(addr_out), .data_out(data_out),
        .ext_in_data(ext_in_data), .ext_in_valid(ext_in_valid), .ext_in_ready(ext_in_ready),
        .ext_out_data(ext_out_data), .ext_out_addr(ext_out_addr),
        .ext_out_valid(ext_out_valid), .ext_out_ready(ext_out_ready),
        .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [2:0] a, input logic [31:0] d);
        chk({tag, "_valid"}, 64'(ext_out_valid), 64'd1);
        chk({tag, "_addr"}, 64'(ext_out_addr), 64'(a));
        chk({tag, "_data"}, 64'(ext_out_data), 64'(d));
    endtask

    initial begin
        rst = 1'b1; req_in = 0; addr_in = 0; out_en = 0; addr_out = 0; data_out = 0;
        ext_in_data = '0; ext_in_valid = '0; ext_out_ready = 0;
        #1;
        chk("rst_io_in", 64'(io_in), 64'd0);
        chk("rst_in_ready", 64'(ext_in_ready), 64'hFF);
        chk("rst_out_valid", 64'(ext_out_valid), 64'd0);
        chk("rst_flags", 64'({err_ovf, err_unf}), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Load channel 3 with 0xA5, then consume it
        ext_in_data[3*32 +: 32] = 32'h0000_00A5; ext_in_valid[3] = 1'b1;
        #1 chk("ch3_ready_empty", 64'(ext_in_ready[3]), 64'd1);
        tick();
        ext_in_valid = '0; addr_in = 3;
        #1 chk("ch3_io_in", 64'(io_in), 64'hA5);
        chk("ch3_ready_full", 64'(ext_in_ready[3]), 64'd0);
        req_in = 1'b1;
        #1 chk("ch3_ready_on_req", 64'(ext_in_ready[3]), 64'd1);
        tick();
        req_in = 1'b0;
        #1 chk("ch3_ready_after", 64'(ext_in_ready[3]), 64'd1);
        chk("ch3_retained", 64'(io_in), 64'hA5);
        chk("no_unf_yet", 64'(err_unf), 64'd0);

        // Channel 2: consume and reload on the same edge
        ext_in_data[2*32 +: 32] = 32'h0000_5555; ext_in_valid[2] = 1'b1;
        tick();
        addr_in = 2; req_in = 1'b1; ext_in_data[2*32 +: 32] = 32'h0000_1234;
        #1 chk("ch2_first", 64'(io_in), 64'h5555);
        tick();
        req_in = 1'b0; ext_in_valid = '0;
        #1 chk("ch2_stays_full", 64'(ext_in_ready[2]), 64'd0);
        chk("ch2_new_word", 64'(io_in), 64'h1234);
        req_in = 1'b1;
        tick();
        req_in = 1'b0;
        #1 chk("ch2_drained", 64'(ext_in_ready[2]), 64'd1);

        // Fill FIFO, then push and pop on the same edge while full
        for (int i = 0; i < 4; i++) begin
            out_en = 1'b1; addr_out = 3'(i); data_out = 32'(20 + i);
            tick();
        end
        out_en = 1'b1; addr_out = 3'd6; data_out = 32'd99; ext_out_ready = 1'b1;
        #1 chk_head("fp_head0", 3'd0, 32'd20);
        tick();
        out_en = 1'b0;
        #1 chk("fp_no_ovf", 64'(err_ovf), 64'd0);
        chk_head("fp_head1", 3'd1, 32'd21); tick();
        chk_head("fp_head2", 3'd2, 32'd22); tick();
        chk_head("fp_head3", 3'd3, 32'd23); tick();
        chk_head("fp_head4", 3'd6, 32'd99); tick();
        chk("fp_empty", 64'(ext_out_valid), 64'd0);

        // Five writes into a depth-4 FIFO with the consumer stalled
        ext_out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            out_en = 1'b1; addr_out = 3'(i + 1); data_out = 32'(10 + i);
            tick();
            if (i == 0) begin
                chk_head("ovf_first_latency", 3'd1, 32'd10);
            end
        end
        out_en = 1'b0;
        #1 chk("ovf_flag", 64'(err_ovf), 64'(EF));
        chk_head("ovf_head_stable", 3'd1, 32'd10);
        ext_out_ready = 1'b1;
        #1 chk_head("drain1", 3'd1, 32'd10); tick();
        chk_head("drain2", 3'd2, 32'd11); tick();
        chk_head("drain3", 3'd3, 32'd12); tick();
        chk_head("drain4", 3'd4, 32'd13); tick();
        chk("drain_empty", 64'(ext_out_valid), 64'd0);
        ext_out_ready = 1'b0;

        // Read an empty channel
        addr_in = 5; req_in = 1'b1;
        tick();
        req_in = 1'b0;
        #1 chk("unf_flag", 64'(err_unf), 64'(EF));

        // Reset mid-transfer with two queued words and channel 0 held
        for (int i = 0; i < 2; i++) begin
            out_en = 1'b1; addr_out = 3'(i); data_out = 32'(40 + i);
            tick();
        end
        out_en = 1'b0;
        ext_in_data[31:0] = 32'hDEAD_BEEF; ext_in_valid[0] = 1'b1;
        tick();
        ext_in_valid = '0; addr_in = 0;
        #1 chk("pre_rst_io_in", 64'(io_in), 64'hDEAD_BEEF);
        chk("pre_rst_valid", 64'(ext_out_valid), 64'd1);
        #2 rst = 1'b1;
        #1 chk("arst_out_valid", 64'(ext_out_valid), 64'd0);
        chk("arst_in_ready", 64'(ext_in_ready), 64'hFF);
        chk("arst_io_in", 64'(io_in), 64'd0);
        chk("arst_flags", 64'({err_ovf, err_unf}), 64'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_valid", 64'(ext_out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/io_responder.md
IO_RESPONDER -- requirements
Module: io_responder

Interface
REQ-001 SHALL have parameter NUBITS, default 32, data word width.
REQ-002 SHALL have parameter NUIOIN, default 8, number of input channels (power of 2, >=2).
REQ-003 SHALL have parameter NUIOOU, default 8, number of output addresses (power of 2, >=2).
REQ-004 SHALL have parameter FDEPTH, default 4, output FIFO depth (power of 2, >=2).
REQ-005 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port req_in  input  1  core input-read strobe.
REQ-008 SHALL have port addr_in  input  clog2(NUIOIN)  core input channel select.
REQ-009 SHALL have port io_in  output  NUBITS  data returned to core.
REQ-010 SHALL have port out_en  input  1  core output-write strobe.
REQ-011 SHALL have port addr_out  input  clog2(NUIOOU)  core output address.
REQ-012 SHALL have port data_out  input  NUBITS  core output data.
REQ-013 SHALL have port ext_in_data  input  NUIOIN*NUBITS  producer words, channel k at bits [k*NUBITS +: NUBITS].
REQ-014 SHALL have port ext_in_valid / ext_in_ready  input / output  NUIOIN  per-channel producer handshake.
REQ-015 SHALL have port ext_out_data / ext_out_addr  output  NUBITS / clog2(NUIOOU)  consumer word and address.
REQ-016 SHALL have port ext_out_valid / ext_out_ready  output / input  1  consumer handshake.
REQ-017 SHALL have port err_ovf / err_unf  output  1  sticky output-overflow / input-underrun flags.

Function
REQ-018 Each input channel k SHALL have a holding register hreg[k] and flag full[k].
REQ-019 ext_in_ready[k] SHALL be combinational: !full[k] | (req_in & addr_in==k).
REQ-020 ext_in_valid[k]&ext_in_ready[k] at an edge SHALL load hreg[k] and set full[k].
REQ-021 io_in SHALL be combinational hreg[addr_in], independent of req_in and full.
REQ-022 req_in at an edge SHALL clear full[addr_in] unless same-edge load on that channel, in which case full stays 1 and hreg takes new word.
REQ-023 hreg SHALL retain its value after consumption (re-read returns last word).
REQ-024 Output FIFO SHALL hold {addr_out,data_out} entries, FDEPTH deep, write/read pointers wrap modulo FDEPTH, count 0..FDEPTH.
REQ-025 out_en at an edge with FIFO not full, or full with same-edge pop, SHALL push one entry.
REQ-026 out_en with FIFO full and no same-edge pop SHALL drop the word, FIFO unchanged.
REQ-027 ext_out_valid SHALL equal (count!=0); ext_out_data/addr SHALL show head entry, stable while valid&!ready.
REQ-028 Pop SHALL occur at an edge with ext_out_valid&ext_out_ready; simultaneous push+pop keeps count.
REQ-029 Latency core write -> ext_out_valid SHALL be 1 cycle on an empty FIFO; no write-through bypass.
REQ-030 Latency producer load -> core visibility on io_in SHALL be 1 cycle.

Reset
REQ-031 rst SHALL asynchronously clear full[], hreg[] to 0, FIFO pointers and count to 0, err_ovf and err_unf to 0.
REQ-032 During/after reset: io_in=0, ext_in_ready all 1, ext_out_valid=0; rst mid-transfer discards FIFO contents and held words.

Configuration
REQ-033 Macro IO_RESPONDER_ERRFLAG_EN SHALL gate the sticky error logic.
REQ-034 With it defined: err_ovf set on a REQ-026 drop; err_unf set on req_in with full[addr_in]==0; both cleared only by rst.
REQ-035 Without it: err_ovf and err_unf tied to 0, no flag registers synthesized; all other behaviour identical.

Verification
REQ-036 Load ch3=0x0000_00A5, then req_in addr_in=3 -> io_in=0xA5, full[3] 1->0, ext_in_ready[3]=1 next cycle.
REQ-037 full[2] held, same edge req_in addr 2 and ext_in_valid[2] with 0x1234 -> full[2] stays 1, io_in addr 2 =0x1234 next cycle.
REQ-038 FDEPTH=4, ext_out_ready=0, five writes (addr 1..5 mod 8, data 10..14) -> count=4, fifth dropped, err_ovf=1 (macro on) / 0 (macro off).
REQ-039 Then ext_out_ready=1 -> outputs (1,10),(2,11),(3,12),(4,13) on consecutive cycles, ext_out_valid low after fourth.
REQ-040 FIFO full, simultaneous out_en(addr 6,data 99) and pop -> count stays 4, (6,99) emerges last, no error.
REQ-041 rst asserted with 2 FIFO entries and full[0]=1 -> immediately ext_out_valid=0, ext_in_ready[0]=1, io_in=0, flags 0.
